car_sprite_addr_gen: RTL and testbench

CAR_SPRITE_ADDR_GEN -- requirements
Module: car_sprite_addr_gen

---
 rtl/car_sprite_pkg.sv | 21 ++
 rtl/car_angle_quant.sv | 27 ++
 rtl/car_sprite_addr_gen.sv | 151 +++++++++++++++
 tb/tb_car_sprite_addr_gen.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/car_sprite_pkg.sv
// Shared constants and defaults for the car sprite address generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package car_sprite_pkg;

    localparam int DEG_FULL = 360;   // degrees in a full turn
    localparam int DEG_W    = 9;     // angle field width, 0..511
    localparam int PIX_W    = 10;    // sprite-local pixel coordinate width

    localparam int SPR_W_DEF      = 75;
    localparam int SPR_H_DEF      = 75;
    localparam int N_FRAMES_DEF   = 16;
    localparam int SHEET_COLS_DEF = 8;
    localparam int N_CARS_DEF     = 2;

    // Index width that never collapses to zero bits for a count of 1.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/car_angle_quant.sv
// Angle-to-rotation-frame quantiser: wraps d>=360 once, then idx = floor(d*N_FRAMES/360).
// Latency: purely combinational.
// Backpressure: none (no handshake).
// Ports: i_deg  - shadow angle 0..511
//        o_idx  - rotation frame index 0..N_FRAMES-1
module car_angle_quant
    import car_sprite_pkg::*;
#(
    parameter  int N_FRAMES = N_FRAMES_DEF,
    localparam int IDX_W    = clog2_min1(N_FRAMES)
) (
    input  logic [DEG_W-1:0] i_deg,
    output logic [IDX_W-1:0] o_idx
);

    logic [DEG_W-1:0] w_deg_wrap;
    logic [31:0]      w_prod;

    always_comb begin
        // A single subtraction suffices: the 9-bit input tops out at 511 < 720.
        w_deg_wrap = (i_deg >= DEG_W'(DEG_FULL)) ? (i_deg - DEG_W'(DEG_FULL)) : i_deg;
        // Multiply before dividing so the floor is exact; never rounds up.
        w_prod     = 32'(w_deg_wrap) * 32'(N_FRAMES);
        o_idx      = IDX_W'(w_prod / 32'(DEG_FULL));
    end

endmodule

// File: rtl/car_sprite_addr_gen.sv
// Sprite ROM address generator: car + rotation frame + sprite-local pixel -> ROM address.
// Latency: 2 cycles (stage 1 resolves frame/oob, stage 2 registers the address).
// Backpressure: valid/ready; each stage advances when empty or when its successor advances.
// Ports: clk, rst (async, active high); frame_start + degree_flat latch per-car angles;
//        in_valid/in_ready/in_car/pixel_x/pixel_y request side;
//        out_valid/out_ready/rom_addr/out_car/out_oob result side.
module car_sprite_addr_gen
    import car_sprite_pkg::*;
#(
    parameter  int SPR_W      = SPR_W_DEF,
    parameter  int SPR_H      = SPR_H_DEF,
    parameter  int N_FRAMES   = N_FRAMES_DEF,
    parameter  int SHEET_COLS = SHEET_COLS_DEF,
    parameter  int N_CARS     = N_CARS_DEF,
    localparam int CAR_W      = clog2_min1(N_CARS),
    localparam int ADDR_W     = $clog2(N_CARS * N_FRAMES * SPR_W * SPR_H)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic [DEG_W*N_CARS-1:0]   degree_flat,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CAR_W-1:0]          in_car,
    input  logic [PIX_W-1:0]          pixel_x,
    input  logic [PIX_W-1:0]          pixel_y,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_W-1:0]         rom_addr,
    output logic [CAR_W-1:0]          out_car,
    output logic                      out_oob
);

    localparam int IDX_W = clog2_min1(N_FRAMES);
    localparam int ROW_W = clog2_min1(N_FRAMES / SHEET_COLS);
    localparam int COL_W = clog2_min1(SHEET_COLS);

    // Per-car angle shadows and their frame indices.
    logic [DEG_W-1:0] r_shadow [N_CARS];
    logic [IDX_W-1:0] w_idx    [N_CARS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_CARS; k++) r_shadow[k] <= '0;
        end else if (frame_start) begin
            for (int k = 0; k < N_CARS; k++) r_shadow[k] <= degree_flat[k*DEG_W +: DEG_W];
        end
    end

    // Quantisers read the registered shadow, so a request accepted alongside
    // frame_start still sees the previous angle.
    for (genvar g = 0; g < N_CARS; g++) begin : g_quant
        car_angle_quant #(.N_FRAMES(N_FRAMES)) u_quant (
            .i_deg (r_shadow[g]),
            .o_idx (w_idx[g])
        );
    end

    // Stage 1 request decode.
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_car_oob;
    logic             w_pix_oob;

    always_comb begin
        w_sel_idx = '0;
        w_car_oob = 1'b1;
        for (int k = 0; k < N_CARS; k++) begin
            if (in_car == CAR_W'(k)) begin
                w_sel_idx = w_idx[k];
                w_car_oob = 1'b0;
            end
        end
        w_pix_oob = (32'(pixel_x) >= 32'(SPR_W)) || (32'(pixel_y) >= 32'(SPR_H));
    end

    // Handshake: readiness flows backwards from out_ready only, never from in_valid.
    logic w_s1_rdy;
    logic w_s2_rdy;
    logic r_s1_vld;
    logic r_out_vld;

    assign w_s2_rdy = !r_out_vld || out_ready;
    assign w_s1_rdy = !r_s1_vld || w_s2_rdy;
    assign in_ready = w_s1_rdy;

    logic [CAR_W-1:0] r_s1_car;
    logic [PIX_W-1:0] r_s1_x;
    logic [PIX_W-1:0] r_s1_y;
    logic [ROW_W-1:0] r_s1_row;
    logic [COL_W-1:0] r_s1_col;
    logic             r_s1_oob;

    logic [ADDR_W-1:0] r_rom_addr;
    logic [CAR_W-1:0]  r_out_car;
    logic              r_out_oob;

    // Stage 2 address, summed in 32 bits and narrowed only at the end.
    logic [31:0] w_addr_full;

    always_comb begin
        w_addr_full = 32'(r_s1_car) * 32'(N_FRAMES * SPR_W * SPR_H)
                    + 32'(r_s1_row) * 32'(SHEET_COLS * SPR_W * SPR_H)
                    + 32'(r_s1_y)   * 32'(SHEET_COLS * SPR_W)
                    + 32'(r_s1_col) * 32'(SPR_W)
                    + 32'(r_s1_x);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_car   <= '0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_row   <= '0;
            r_s1_col   <= '0;
            r_s1_oob   <= 1'b0;
            r_out_vld  <= 1'b0;
            r_rom_addr <= '0;
            r_out_car  <= '0;
            r_out_oob  <= 1'b0;
        end else begin
            if (w_s1_rdy) begin
                r_s1_vld <= in_valid;
                if (in_valid) begin
                    r_s1_car <= in_car;
                    r_s1_x   <= pixel_x;
                    r_s1_y   <= pixel_y;
                    r_s1_row <= ROW_W'(32'(w_sel_idx) / 32'(SHEET_COLS));
                    r_s1_col <= COL_W'(32'(w_sel_idx) % 32'(SHEET_COLS));
                    r_s1_oob <= w_pix_oob || w_car_oob;
                end
            end
            // Output registers only move when the consumer can take them,
            // which keeps them stable during a stall.
            if (w_s2_rdy) begin
                r_out_vld <= r_s1_vld;
                if (r_s1_vld) begin
                    r_rom_addr <= r_s1_oob ? '0 : ADDR_W'(w_addr_full);
                    r_out_car  <= r_s1_car;
                    r_out_oob  <= r_s1_oob;
                end
            end
        end
    end

    assign out_valid = r_out_vld;
    assign rom_addr  = r_rom_addr;
    assign out_car   = r_out_car;
    assign out_oob   = r_out_oob;

endmodule

// File: tb/tb_car_sprite_addr_gen.sv
// Bench for car_sprite_addr_gen: directed vectors, scoreboard model, literal pins.
// Latency: n/a.
// Backpressure: out_ready toggled by the stimulus.
module tb_car_sprite_addr_gen;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic [17:0] degree_flat;
    logic        in_valid;
    logic        in_ready;
    logic        in_car;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] rom_addr;
    logic        out_car;
    logic        out_oob;

    // Three-car instance so an in_car beyond N_CARS is representable.
    logic [26:0] degree_flat3;
    logic [1:0]  in_car3;
    logic        in_ready3;
    logic        out_valid3;
    logic [18:0] rom_addr3;
    logic [1:0]  out_car3;
    logic        out_oob3;

    car_sprite_addr_gen dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .degree_flat(degree_flat),
        .in_valid(in_valid), .in_ready(in_ready), .in_car(in_car),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .out_valid(out_valid), .out_ready(out_ready), .rom_addr(rom_addr),
        .out_car(out_car), .out_oob(out_oob)
    );

    car_sprite_addr_gen #(.N_CARS(3)) dut3 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .degree_flat(degree_flat3),
        .in_valid(in_valid), .in_ready(in_ready3), .in_car(in_car3),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .out_valid(out_valid3), .out_ready(out_ready), .rom_addr(rom_addr3),
        .out_car(out_car3), .out_oob(out_oob3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: spec formula with plain integers.
    typedef struct {
        int     car;
        longint addr;
        bit     oob;
    } exp_t;

    function automatic exp_t model(input int car, input int x, input int y, input int deg);
        exp_t e;
        int   d;
        int   idx;
        e.car = car;
        if (car >= 2 || x >= 75 || y >= 75) begin
            e.addr = 0;
            e.oob  = 1'b1;
            return e;
        end
        d   = (deg >= 360) ? deg - 360 : deg;
        idx = (d * 16) / 360;
        e.addr = longint'(car) * 90000 + (idx / 8) * 45000 + y * 600 + (idx % 8) * 75 + x;
        e.oob  = 1'b0;
        return e;
    endfunction

    exp_t q[$];
    int   mdeg[2];

    // Scoreboard: one compare per cycle whenever a result is presented.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            mdeg[0] = 0;
            mdeg[1] = 0;
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", out_valid, 0);
                end else begin
                    check("sb_out_car",  out_car,  q[0].car);
                    check("sb_rom_addr", rom_addr, q[0].addr);
                    check("sb_out_oob",  out_oob,  q[0].oob);
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready)
                q.push_back(model(int'(in_car), int'(pixel_x), int'(pixel_y), mdeg[in_car]));
            if (frame_start) begin
                mdeg[0] = int'(degree_flat[8:0]);
                mdeg[1] = int'(degree_flat[17:9]);
            end
        end
    end

    // Present one request and return #1 after the edge that accepted it.
    task automatic req(input int car, input int car3, input int x, input int y);
        int n;
        bit acc;
        n        = 0;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_car   = car[0];
        in_car3  = car3[1:0];
        pixel_x  = x[9:0];
        pixel_y  = y[9:0];
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("accept_timeout", acc, 1);
    endtask

    // Single request into an empty pipe; literal expectations with exact latency.
    task automatic req_chk(input string name, input int car, input int x, input int y,
                           input longint exp_addr, input bit exp_oob);
        req(car, car, x, y);
        in_valid = 1'b0;
        check({name, "_not_early"}, out_valid, 0);
        @(posedge clk); #1;
        check({name, "_valid"}, out_valid, 1);
        check({name, "_addr"},  rom_addr,  exp_addr);
        check({name, "_oob"},   out_oob,   exp_oob);
        @(posedge clk); #1;
    endtask

    task automatic set_deg(input int d0, input int d1);
        degree_flat = {d1[8:0], d0[8:0]};
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int c0;
        rst          = 1'b1;
        frame_start  = 1'b0;
        degree_flat  = '0;
        degree_flat3 = '0;
        in_valid     = 1'b0;
        in_car       = 1'b0;
        in_car3      = 2'd0;
        pixel_x      = '0;
        pixel_y      = '0;
        out_ready    = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_rom_addr",  rom_addr,  0);
        check("rst_out_car",   out_car,   0);
        check("rst_out_oob",   out_oob,   0);
        rst = 1'b0;
        check("rst_release_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Shadows reset to 0 degrees.
        req_chk("car0_0deg", 0, 0, 0, 0, 1'b0);

        set_deg(90, 200);
        req_chk("car0_90deg",  0, 10, 2,  1510,   1'b0);
        req_chk("car1_200deg", 1, 74, 74, 179474, 1'b0);

        set_deg(370, 511);
        req_chk("car0_370deg", 0, 5, 0, 5,     1'b0);
        req_chk("car1_511deg", 1, 0, 0, 90450, 1'b0);

        set_deg(338, 23);
        req_chk("car0_338deg", 0, 0, 0, 45525, 1'b0);
        req_chk("car1_23deg",  1, 0, 0, 90075, 1'b0);

        req_chk("oob_x75", 0, 75, 0, 0, 1'b1);
        req_chk("oob_y75", 1, 3, 75, 0, 1'b1);

        // Car select beyond N_CARS on the three-car instance.
        req(0, 3, 1, 1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("car3_valid", out_valid3, 1);
        check("car3_addr",  rom_addr3,  0);
        check("car3_oob",   out_oob3,   1);
        @(posedge clk); #1;
        req(0, 2, 0, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("car2_addr", rom_addr3, 180000);
        check("car2_oob",  out_oob3,  0);
        @(posedge clk); #1;

        // Back-to-back acceptance at one per cycle.
        c0 = cyc;
        for (int i = 0; i < 4; i++) req(i % 2, 0, i * 7, i * 3);
        in_valid = 1'b0;
        check("throughput_cycles", cyc - c0, 4);
        drain();

        // Six requests with a 3-cycle output stall mid-stream.
        fork
            begin
                for (int i = 0; i < 6; i++) req(i % 2, 0, 10 + i, 20 + i * 9);
                in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                check("stall_in_ready_low", in_ready, 0);
                check("stall_out_valid",    out_valid, 1);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // frame_start in the same cycle as a request: old angle applies to it.
        set_deg(0, 0);
        degree_flat = 18'd90;
        frame_start = 1'b1;
        req(0, 0, 0, 0);
        frame_start = 1'b0;
        req(0, 0, 0, 0);
        in_valid = 1'b0;
        check("fs_same_cycle_addr", rom_addr, 0);
        @(posedge clk); #1;
        check("fs_next_req_valid", out_valid, 1);
        check("fs_next_req_addr",  rom_addr,  300);
        @(posedge clk); #1;

        // Reset while requests are in flight.
        req(0, 0, 1, 1);
        req(1, 0, 2, 2);
        #2;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("midrst_quiet", out_valid, 0);
        end
        check("final_queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
